// File: rtl/dmem_arbiter_ctrl_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package dmem_pkg;

    typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_RSV = 2'b11} size_e;
    typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} st_e;
    typedef enum logic {P_C = 1'b0, P_D = 1'b1} port_e;

    // Lane 0 always carries the addressed byte, so enables depend only on size.
    function automatic logic [3:0] be_of(input size_e sz);
        case (sz)
            SZ_B:    be_of = 4'b0001;
            SZ_H:    be_of = 4'b0011;
            default: be_of = 4'b1111;
        endcase
    endfunction

    // Half needs addr[0]=0; word (and reserved, treated as word) needs addr[1:0]=00.
    function automatic logic misaligned(input size_e sz, input logic [1:0] a);
        case (sz)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = a[0];
            default: misaligned = (a != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_arbiter_ctrl_if.sv
// Bundle of both requester ports and the data-memory side of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req and fields until gnt.
interface dmem_arbiter_ctrl_if #(parameter int ADDR_W = 32);
    logic              c_req, c_we, c_unsigned, c_gnt, c_rvalid, c_err;
    logic [1:0]        c_size;
    logic [ADDR_W-1:0] c_addr;
    logic [31:0]       c_wdata, c_rdata;
    logic              d_req, d_we, d_unsigned, d_gnt, d_rvalid, d_err;
    logic [1:0]        d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata, d_rdata;
    logic [ADDR_W-1:0] mem_raddr, mem_waddr;
    logic [31:0]       mem_wdata, mem_rdata;
    logic [3:0]        mem_wr;

    // Requesters and memory model side.
    modport master (
        output c_req, c_we, c_size, c_unsigned, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata, c_err,
        output d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_raddr, mem_waddr, mem_wdata, mem_wr,
        output mem_rdata
    );

    // Arbiter side.
    modport slave (
        input  c_req, c_we, c_size, c_unsigned, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata, c_err,
        input  d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_raddr, mem_waddr, mem_wdata, mem_wr,
        input  mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter_ctrl_load_fmt.sv
// Sign/zero extension of raw memory read data according to access size.
// Latency: combinational.
// Backpressure: none.
module dmem_load_fmt
    import dmem_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  size_e       size,
    input  logic        is_unsigned,
    output logic [31:0] rdata
);

    // Byte and half take the low lanes; word and reserved pass through.
    always_comb begin
        rdata = mem_rdata;
        case (size)
            SZ_B:    rdata = {{24{mem_rdata[7]  & ~is_unsigned}}, mem_rdata[7:0]};
            SZ_H:    rdata = {{16{mem_rdata[15] & ~is_unsigned}}, mem_rdata[15:0]};
            default: rdata = mem_rdata;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter_ctrl.sv
// Round-robin share of the byte-banked data memory between CPU port C and debug port D; optional DMEM_MISALIGN_TRAP_EN.
// Latency: store granted and written in the same cycle; load data returned one cycle after grant.
// Backpressure: gnt is withheld while a load is in RD_WAIT and from the losing port on a tie.
module dmem_arbiter_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RR_INIT_C = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    dmem_arbiter_ctrl_if.slave bus
);

    localparam port_e LAST_INIT = (RR_INIT_C != 0) ? P_D : P_C;

    st_e               st_q, st_d;
    port_e             last_q, last_d, own_q, sel;
    size_e             size_q, s_size;
    logic              uns_q, s_uns, s_we, any, mis, cap;
    logic [ADDR_W-1:0] raddr_q, s_addr;
    logic [31:0]       s_wdata;
    logic [DATA_W-1:0] fmt_rdata;
    logic              err_q, err_d;

    // Pick the winner in IDLE and mux its request fields.
    always_comb begin
        any = 1'b0;
        sel = P_C;
        if (st_q == IDLE && rst_n) begin
            if (bus.c_req && bus.d_req) begin
                any = 1'b1;
                sel = (last_q == P_C) ? P_D : P_C;
            end else if (bus.c_req) begin
                any = 1'b1;
                sel = P_C;
            end else if (bus.d_req) begin
                any = 1'b1;
                sel = P_D;
            end
        end
        s_we    = (sel == P_C) ? bus.c_we       : bus.d_we;
        s_size  = size_e'((sel == P_C) ? bus.c_size : bus.d_size);
        s_uns   = (sel == P_C) ? bus.c_unsigned : bus.d_unsigned;
        s_addr  = (sel == P_C) ? bus.c_addr     : bus.d_addr;
        s_wdata = (sel == P_C) ? bus.c_wdata    : bus.d_wdata;
`ifdef DMEM_MISALIGN_TRAP_EN
        mis = misaligned(s_size, s_addr[1:0]);
`else
        mis = 1'b0;
`endif
    end

    dmem_load_fmt u_fmt (
        .mem_rdata   (bus.mem_rdata),
        .size        (size_q),
        .is_unsigned (uns_q),
        .rdata       (fmt_rdata)
    );

    // Next state and all outputs; everything defaults to zero.
    always_comb begin
        st_d          = st_q;
        last_d        = last_q;
        cap           = 1'b0;
        err_d         = 1'b0;
        bus.c_gnt     = 1'b0;
        bus.d_gnt     = 1'b0;
        bus.c_rvalid  = 1'b0;
        bus.d_rvalid  = 1'b0;
        bus.c_rdata   = '0;
        bus.d_rdata   = '0;
        bus.c_err     = 1'b0;
        bus.d_err     = 1'b0;
        bus.mem_raddr = '0;
        bus.mem_waddr = '0;
        bus.mem_wdata = '0;
        bus.mem_wr    = 4'b0000;
        case (st_q)
            IDLE: begin
                if (any) begin
                    bus.c_gnt = (sel == P_C);
                    bus.d_gnt = (sel == P_D);
                    last_d    = sel;
                    if (mis) begin
                        cap   = 1'b1;
                        err_d = 1'b1;
                        st_d  = RD_WAIT;
                    end else if (s_we) begin
                        bus.mem_waddr = s_addr;
                        bus.mem_wdata = s_wdata;
                        bus.mem_wr    = be_of(s_size);
                    end else begin
                        bus.mem_raddr = s_addr;
                        cap           = 1'b1;
                        st_d          = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                bus.mem_raddr = raddr_q;
                st_d          = IDLE;
                if (own_q == P_C) begin
                    bus.c_rvalid = ~err_q;
                    bus.c_rdata  = err_q ? '0 : fmt_rdata;
                    bus.c_err    = err_q;
                end else begin
                    bus.d_rvalid = ~err_q;
                    bus.d_rdata  = err_q ? '0 : fmt_rdata;
                    bus.d_err    = err_q;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    // State, round-robin pointer and captured load context.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= IDLE;
            last_q  <= LAST_INIT;
            own_q   <= P_C;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            raddr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            st_q   <= st_d;
            last_q <= last_d;
            if (cap) begin
                own_q   <= sel;
                size_q  <= s_size;
                uns_q   <= s_uns;
                raddr_q <= s_addr;
                err_q   <= err_d;
            end
        end
    end

endmodule

// File: doc/dmem_arbiter_ctrl.md
Name: dmem_arbiter_ctrl

Overview:
Sequences and shares the byte-banked 32-bit data memory between two requesters: the CPU load/store port (port C) and the debug/loader port (port D).
- Arbitrates round-robin between the ports.
- Generates the 4-bit byte-write enable.
- Handles the RAM's 1-cycle synchronous read latency.
- Sign- or zero-extends load data.

Sits between the CPU load/store stage and the data memory.

Parameters:
ADDR_W, 32, width of the requester and memory addresses
DATA_W, 32, data width; only 32 is supported
RR_INIT_C, 1, after reset, port C wins the first tie

Ports:
clk  in  1  clock (rising edge)
rst_n  in  1  asynchronous, active-low reset
c_req  in  1  port C request; held with its fields until c_gnt
c_we  in  1  1 = store, 0 = load
c_size  in  2  00 byte, 01 half, 10 word, 11 reserved
c_unsigned  in  1  zero-extend on load (LBU/LHU)
c_addr  in  ADDR_W  byte address
c_wdata  in  32  store data, right-aligned
c_gnt  out  1  request accepted this cycle (combinational)
c_rvalid  out  1  load data valid
c_rdata  out  32  extended load data
c_err  out  1  access rejected (only with the optional feature)
d_req, d_we, d_size, d_unsigned, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata, d_err: same as port C, for port D
mem_raddr  out  ADDR_W  memory read address
mem_waddr  out  ADDR_W  memory write address
mem_wdata  out  32  memory write data
mem_wr  out  4  byte-lane write enables
mem_rdata  in  32  memory read data (valid 1 cycle after mem_raddr)

Behaviour:
- FSM states: IDLE, RD_WAIT.
  - Grants are issued only in IDLE.
  - In RD_WAIT, gnt is 0 for both ports.
- Arbitration (IDLE):
  - Single requester: it is granted.
  - Both requesting: the port not granted last wins.
  - The last-winner pointer updates on every grant.
- Store grant (cycle G):
  - mem_waddr = addr, mem_wdata = wdata.
  - mem_wr: byte 0001, half 0011, word or reserved 1111.
  - Lane 0 always maps to addr, so no shifting is applied.
  - FSM stays in IDLE, giving 1 store per cycle.
- Load grant (cycle G):
  - mem_raddr = addr, mem_wr = 0000.
  - Requester ID, size and unsigned are registered; FSM goes to RD_WAIT.
- RD_WAIT (cycle G+1):
  - The owner's rvalid = 1 for exactly one cycle; rdata is formatted from mem_rdata.
    - byte: bits [7:0], sign- or zero-extended
    - half: bits [15:0], sign- or zero-extended
    - word: pass-through
  - mem_raddr holds the registered address.
  - FSM returns to IDLE, giving 1 load per 2 cycles.
- Outputs at all times:
  - mem_wr is 0000 except in a store grant cycle.
  - The non-owner's rvalid is 0 and its rdata is 0.
- Reset (asynchronous, any state):
  - FSM goes to IDLE; all outputs are 0.
  - Pointer is set so port C wins the next tie.
  - A load in flight is dropped; no rvalid is issued.
- A requester that drops req before gnt is legal; nothing is performed.
- Simultaneous store on C and load on D: one is granted per the pointer; the other waits.

Optional Feature:
DMEM_MISALIGN_TRAP_EN
- Defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]≠00, is granted but suppressed: mem_wr = 0000 and no read.
  - err is pulsed at G+1 (rvalid = 0); the FSM passes through RD_WAIT for uniform timing.
- Undefined:
  - Misaligned accesses proceed; the banked memory handles them natively.
  - err outputs are tied to 0.

Decomposition:
- Package dmem_pkg:
  - enum size_e {SZ_B, SZ_H, SZ_W, SZ_RSV}
  - enum st_e {IDLE, RD_WAIT}
  - enum port_e {P_C, P_D}
  - function be_of(size_e) returning 4 bits
- Sub-module dmem_load_fmt: purely combinational sign/zero extension (mem_rdata, size, unsigned → rdata).

Test Plan:
1. Port C SB addr 0x10, wdata 0x123456AB → mem_wr 0001, mem_waddr 0x10; then LB 0x10 → rvalid at G+1, rdata 0xFFFFFFAB. LBU → 0x000000AB.
2. Both ports issue a load at once after reset → C granted in cycle 1 with rdata at cycle 2; D granted in cycle 3 (no grant during RD_WAIT); the next tie goes to C.
3. Port C issues SW to 0x20, 0x24, 0x28 back-to-back → three consecutive gnt cycles, mem_wr 1111 each; LH of 0x20 holding 0x00008001 → 0xFFFF8001.
4. Assert rst_n=0 in the RD_WAIT cycle → no rvalid, all outputs 0; after release, the tie goes to C.
5. With DMEM_MISALIGN_TRAP_EN: SW to 0x22 → gnt, mem_wr 0000, c_err=1 at G+1. Without the macro → mem_wr 1111, no error.
6. Reserved size 11, load of 0x89ABCDEF → rdata 0x89ABCDEF; as a store → mem_wr 1111.
